// File: rtl/prog_timer_pkg.sv
// prog_timer_pkg
//   Shared types for the programmable timer block.
//   ch_state_e : per-channel control state (IDLE, RUN)
//   mode_e     : per-channel countdown mode (ONESHOT, PERIODIC)
package prog_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  typedef enum logic {
    ONESHOT  = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/prog_timer_ch.sv
// prog_timer_ch
//   One independent countdown channel of the programmable timer.
//   Ports:
//     clk_i     - clock, rising edge
//     rst_i     - synchronous active-high reset
//     tick      - countdown enable shared by all channels
//     start     - one-cycle start/restart strobe (latches load and periodic)
//     abort     - one-cycle abort strobe
//     hold      - level, freezes a running channel
//     periodic  - mode sampled with start (0 one-shot, 1 periodic)
//     load      - load value N sampled with start
//     busy      - channel is in RUN
//     done      - registered one-cycle expiry pulse
//     done_nxt  - value done will take after the next edge (feeds the shared irq register)
//     count     - current counter value
module prog_timer_ch
  import prog_timer_pkg::*;
#(
  parameter int WIDTH_G = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               tick,
  input  logic               start,
  input  logic               abort,
  input  logic               hold,
  input  logic               periodic,
  input  logic [WIDTH_G-1:0] load,
  output logic               busy,
  output logic               done,
  output logic               done_nxt,
  output logic [WIDTH_G-1:0] count
);

  ch_state_e          state_q, state_n;
  mode_e              mode_q, mode_n;
  logic [WIDTH_G-1:0] count_q, count_n;
  logic [WIDTH_G-1:0] reload_q, reload_n;
  logic               done_q;
  logic               done_n;
  // Set on a one-shot expiry so the channel stays busy during the done
  // cycle and drops to IDLE on the following edge.
  logic               expired_q, expired_n;

  // State and datapath registers; reset clears everything including the
  // latched load value and mode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mode_q    <= ONESHOT;
      count_q   <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      mode_q    <= mode_n;
      count_q   <= count_n;
      reload_q  <= reload_n;
      done_q    <= done_n;
      expired_q <= expired_n;
    end
  end

  // Next-state logic. Priority is abort, then start, then hold, then the
  // tick-driven countdown. The done pulse is produced only by a genuine
  // expiry, so an abort or restart on the expiry cycle swallows it.
  always_comb begin
    state_n   = state_q;
    mode_n    = mode_q;
    count_n   = count_q;
    reload_n  = reload_q;
    done_n    = 1'b0;
    expired_n = expired_q;

    if (abort) begin
      state_n   = IDLE;
      count_n   = '0;
      expired_n = 1'b0;
    end else if (start) begin
      state_n   = RUN;
      count_n   = load;
      reload_n  = load;
      mode_n    = periodic ? PERIODIC : ONESHOT;
      expired_n = 1'b0;
    end else if (state_q == RUN && !hold) begin
      if (expired_q) begin
        state_n   = IDLE;
        expired_n = 1'b0;
      end else if (tick) begin
        if (count_q != '0) begin
          count_n = count_q - {{(WIDTH_G-1){1'b0}}, 1'b1};
        end else begin
          done_n = 1'b1;
          if (mode_q == PERIODIC) begin
            count_n = reload_q;
          end else begin
            expired_n = 1'b1;
          end
        end
      end
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign done_nxt = done_n;
  assign count    = count_q;

endmodule

// File: rtl/prog_timer.sv
// prog_timer
//   Multi-channel programmable countdown timer with a shared interrupt.
//   Optional feature macro: PROG_TIMER_PRESC_EN enables a shared prescaler
//   that produces one tick every PRESC_G cycles; without it every cycle ticks.
//   Parameters: NUM_CH_G (1..16), WIDTH_G (2..32), PRESC_G (>=1)
//   Ports:
//     clk_i      - clock, rising edge
//     rst_i      - synchronous active-high reset
//     start_i    - per-channel start/restart strobe
//     abort_i    - per-channel abort strobe
//     hold_i     - per-channel hold level
//     periodic_i - per-channel mode, sampled with start_i
//     load_i     - per-channel load values, channel k at [k*WIDTH_G +: WIDTH_G]
//     busy_o     - per-channel RUN indication
//     done_o     - per-channel registered expiry pulse
//     count_o    - per-channel counter values, same packing as load_i
//     irq_o      - registered OR of all done pulses, aligned with done_o
module prog_timer
  import prog_timer_pkg::*;
#(
  parameter int NUM_CH_G = 4,
  parameter int WIDTH_G  = 16,
  parameter int PRESC_G  = 100
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH_G-1:0]         start_i,
  input  logic [NUM_CH_G-1:0]         abort_i,
  input  logic [NUM_CH_G-1:0]         hold_i,
  input  logic [NUM_CH_G-1:0]         periodic_i,
  input  logic [NUM_CH_G*WIDTH_G-1:0] load_i,
  output logic [NUM_CH_G-1:0]         busy_o,
  output logic [NUM_CH_G-1:0]         done_o,
  output logic [NUM_CH_G*WIDTH_G-1:0] count_o,
  output logic                        irq_o
);

  logic                tick;
  logic [NUM_CH_G-1:0] done_nxt;
  logic                irq_q;

`ifdef PROG_TIMER_PRESC_EN
  localparam int PW = (PRESC_G > 1) ? $clog2(PRESC_G) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_G - 1);

  logic [PW-1:0] presc_q;

  // Free-running divider shared by all channels; it is not resynchronised
  // by start, so the first tick of a fresh countdown lands anywhere within
  // one prescaler period.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  assign tick = (presc_q == PRESC_LAST);
`else
  assign tick = 1'b1;
`endif

  for (genvar k = 0; k < NUM_CH_G; k++) begin : g_ch
    prog_timer_ch #(
      .WIDTH_G (WIDTH_G)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .tick     (tick),
      .start    (start_i[k]),
      .abort    (abort_i[k]),
      .hold     (hold_i[k]),
      .periodic (periodic_i[k]),
      .load     (load_i[k*WIDTH_G +: WIDTH_G]),
      .busy     (busy_o[k]),
      .done     (done_o[k]),
      .done_nxt (done_nxt[k]),
      .count    (count_o[k*WIDTH_G +: WIDTH_G])
    );
  end

  // The interrupt is registered from the channels' next-done values so it
  // rises and falls in exactly the same cycle as the done_o bits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |done_nxt;
    end
  end

  assign irq_o = irq_q;

endmodule
